// File: rtl/timer_ctrl.sv
// timer_ctrl: APB-style register front end for one 8-bit timer counter.
// Holds the start value (TDR) and control (TCR) registers, mirrors the
// counter flags (TSR), divides clk down to the counter tick, and issues
// the single-cycle load / flag-clear pulses plus a registered interrupt.
module timer_ctrl #(
   parameter logic [7:0] RST_TDR = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   input  logic [7:0] tcnt,
   input  logic       overflow,
   input  logic       underflow,
   output logic       clk_ena,
   output logic [7:0] start_counter,
   output logic       up_down,
   output logic       enable,
   output logic       load,
   output logic       clr_overflow,
   output logic       clr_underflow,
   output logic       irq
);

   localparam logic [7:0] ADDR_TDR  = 8'h00;
   localparam logic [7:0] ADDR_TCR  = 8'h01;
   localparam logic [7:0] ADDR_TSR  = 8'h02;
   localparam logic [7:0] ADDR_TCNT = 8'h03;

   logic [7:0] tdr;
   logic       tcr_en;
   logic       tcr_up;
   logic [1:0] tcr_cks;
   logic       tcr_ovie;
   logic       tcr_udie;
   logic [3:0] div;

   logic       setup_phase;
   logic       access_phase;
   logic       addr_bad;
   logic       wr_commit;
   logic       wr_tdr;
   logic       wr_tcr;
   logic       wr_tsr;
   logic [7:0] rd_mux;
   logic       div_full;

   // Bus phase decode; an errored write is masked here so it can never commit.
   always_comb begin
      setup_phase  = psel & ~penable;
      access_phase = psel & penable;
      addr_bad     = (paddr > ADDR_TCNT) | (pwrite & (paddr == ADDR_TCNT));
      wr_commit    = access_phase & pwrite & ~addr_bad;
      wr_tdr       = wr_commit & (paddr == ADDR_TDR);
      wr_tcr       = wr_commit & (paddr == ADDR_TCR);
      wr_tsr       = wr_commit & (paddr == ADDR_TSR);
   end

   // Read data selection; LD and the reserved TCR bit always read back as 0.
   always_comb begin
      rd_mux = 8'h00;
      case (paddr)
         ADDR_TDR:  rd_mux = tdr;
         ADDR_TCR:  rd_mux = {2'b00, tcr_udie, tcr_ovie, tcr_cks, tcr_up, tcr_en};
         ADDR_TSR:  rd_mux = {6'b000000, underflow, overflow};
         ADDR_TCNT: rd_mux = tcnt;
         default:   rd_mux = 8'h00;
      endcase
   end

   // Terminal count of the prescaler: low CKS+1 bits of div all ones.
   always_comb begin
      div_full = 1'b0;
      case (tcr_cks)
         2'd0:    div_full = div[0];
         2'd1:    div_full = &div[1:0];
         2'd2:    div_full = &div[2:0];
         default: div_full = &div;
      endcase
   end

   // Configuration registers updated on a committed write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tdr      <= RST_TDR;
         tcr_en   <= 1'b0;
         tcr_up   <= 1'b0;
         tcr_cks  <= 2'd0;
         tcr_ovie <= 1'b0;
         tcr_udie <= 1'b0;
      end else begin
         if (wr_tdr) begin
            tdr <= pwdata;
         end
         if (wr_tcr) begin
            tcr_en   <= pwdata[0];
            tcr_up   <= pwdata[1];
            tcr_cks  <= pwdata[3:2];
            tcr_ovie <= pwdata[4];
            tcr_udie <= pwdata[5];
         end
      end
   end

   // Read data and error response captured at the setup edge, valid during access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prdata  <= 8'h00;
         pslverr <= 1'b0;
      end else if (setup_phase) begin
         prdata  <= rd_mux;
         pslverr <= addr_bad;
      end else begin
         pslverr <= 1'b0;
      end
   end

   // Single-cycle command pulses and the registered interrupt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load          <= 1'b0;
         clr_overflow  <= 1'b0;
         clr_underflow <= 1'b0;
         irq           <= 1'b0;
      end else begin
         load          <= wr_tcr & pwdata[7];
         clr_overflow  <= wr_tsr & pwdata[0];
         clr_underflow <= wr_tsr & pwdata[1];
         irq           <= (overflow & tcr_ovie) | (underflow & tcr_udie);
      end
   end

   // Prescaler: restarts from 0 on any TCR write so a CKS change never yields a short tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= 4'd0;
      end else if (!tcr_en || load || wr_tcr) begin
         div <= 4'd0;
      end else begin
         div <= div + 4'd1;
      end
   end

   assign pready        = 1'b1;
   assign start_counter = tdr;
   assign up_down       = tcr_up;
   assign enable        = tcr_en;
   assign clk_ena       = tcr_en & ~load & div_full;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl.
// Inputs change on the falling edge and outputs are sampled there too,
// half a period away from the rising edge the design acts on.
module tb_timer_ctrl;

   localparam logic [7:0] RST_VAL = 8'hA5;

   logic       clk;
   logic       rst;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;
   logic [7:0] tcnt;
   logic       overflow;
   logic       underflow;
   logic       clk_ena;
   logic [7:0] start_counter;
   logic       up_down;
   logic       enable;
   logic       load;
   logic       clr_overflow;
   logic       clr_underflow;
   logic       irq;

   int checks = 0;
   int errors = 0;

   timer_ctrl #(.RST_TDR(RST_VAL)) dut (
      .clk(clk),
      .rst(rst),
      .psel(psel),
      .penable(penable),
      .pwrite(pwrite),
      .paddr(paddr),
      .pwdata(pwdata),
      .prdata(prdata),
      .pready(pready),
      .pslverr(pslverr),
      .tcnt(tcnt),
      .overflow(overflow),
      .underflow(underflow),
      .clk_ena(clk_ena),
      .start_counter(start_counter),
      .up_down(up_down),
      .enable(enable),
      .load(load),
      .clr_overflow(clr_overflow),
      .clr_underflow(clr_underflow),
      .irq(irq)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Two-phase write; returns at the falling edge of the cycle after the commit edge.
   task automatic apply_stimulus(input logic [7:0] addr, input logic [7:0] data,
                                 output logic err);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(negedge clk);
      penable = 1'b1;
      #1 err = pslverr;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   // Two-phase read; data and error sampled during the access phase.
   task automatic bus_read(input logic [7:0] addr, output logic [7:0] data,
                           output logic err);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      @(negedge clk);
      penable = 1'b1;
      #1 data = prdata;
      err = pslverr;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      logic       err;
      int         ticks;
      int         bad;
      int         first_k;
      int         second_k;
      int         load_hits;
      int         n;
      logic [7:0] tcr_val;

      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h00; pwdata = 8'h00; tcnt = 8'h3E; overflow = 1'b0; underflow = 1'b0;

      // Reset state, observed with no clock edge yet.
      #3;
      check_output("rst_prdata", prdata, 0);
      check_output("rst_pready", pready, 1);
      check_output("rst_pslverr", pslverr, 0);
      check_output("rst_clk_ena", clk_ena, 0);
      check_output("rst_start", start_counter, RST_VAL);
      check_output("rst_updown_en", {up_down, enable}, 0);
      check_output("rst_pulses", {load, clr_overflow, clr_underflow, irq}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      bus_read(8'h01, rd, err);
      check_output("rd_tcr_reset", rd, 8'h00);
      bus_read(8'h00, rd, err);
      check_output("rd_tdr_reset", rd, RST_VAL);
      bus_read(8'h03, rd, err);
      check_output("rd_tcnt", rd, 8'h3E);

      // Down count: TDR=255, TCR=EN|LD, CKS=0.
      apply_stimulus(8'h00, 8'hFF, err);
      check_output("tdr_start", start_counter, 8'hFF);
      apply_stimulus(8'h01, 8'h81, err);
      check_output("ld_pulse", load, 1);
      check_output("ld_enable_updown", {enable, up_down}, 2'b10);
      // k counts falling edges from here: load holds div at 0 for one more
      // edge, so /2 ticks are high at k = 2, 4, ..., the 256th at k = 512.
      ticks = 0; bad = 0; load_hits = 0;
      for (int k = 0; k <= 512; k++) begin
         if (k > 0) @(negedge clk);
         if (k > 0 && load) load_hits++;
         if (clk_ena) ticks++;
         if (clk_ena !== ((k >= 2) && (k % 2 == 0))) bad++;
      end
      check_output("ld_pulse_width", load_hits, 0);
      check_output("div2_pattern", bad, 0);
      check_output("div2_tick_count", ticks, 256);
      underflow = 1'b1;
      bus_read(8'h02, rd, err);
      check_output("rd_tsr_udf", rd, 8'h02);

      // Prescaler: after a TCR write div restarts at 0, so the tick is high
      // at k = N-1 and then every N cycles (CKS changes mid-run each time).
      for (int c = 0; c < 4; c++) begin
         n = 2 << c;
         tcr_val = 8'h01 | 8'(c << 2);
         apply_stimulus(8'h01, tcr_val, err);
         first_k = -1; second_k = -1;
         for (int k = 0; k <= 2 * n; k++) begin
            if (k > 0) @(negedge clk);
            if (clk_ena) begin
               if (first_k < 0) first_k = k;
               else if (second_k < 0) second_k = k;
            end
         end
         check_output($sformatf("cks%0d_first", c), first_k, n - 1);
         check_output($sformatf("cks%0d_spacing", c), second_k - first_k, n);
      end

      // Interrupt and flag clears; underflow is already set.
      apply_stimulus(8'h01, 8'h21, err);
      check_output("irq_lag", irq, 0);
      @(negedge clk);
      check_output("irq_set", irq, 1);
      apply_stimulus(8'h02, 8'h02, err);
      check_output("clr_ud_pulse", {clr_overflow, clr_underflow}, 2'b01);
      @(negedge clk);
      check_output("clr_ud_width", clr_underflow, 0);
      underflow = 1'b0;
      check_output("irq_hold", irq, 1);
      @(negedge clk);
      check_output("irq_drop", irq, 0);
      apply_stimulus(8'h02, 8'h03, err);
      check_output("clr_both", {clr_overflow, clr_underflow}, 2'b11);
      @(negedge clk);
      check_output("clr_both_width", {clr_overflow, clr_underflow}, 2'b00);
      overflow = 1'b1;
      bus_read(8'h02, rd, err);
      check_output("rd_tsr_ovf", rd, 8'h01);
      overflow = 1'b0;

      // Bus errors and the write-only LD bit.
      bus_read(8'h05, rd, err);
      check_output("bad_rd_err", err, 1);
      check_output("bad_rd_data", rd, 8'h00);
      apply_stimulus(8'h05, 8'h00, err);
      check_output("bad_wr_err", err, 1);
      bus_read(8'h00, rd, err);
      check_output("tdr_unchanged", rd, 8'hFF);
      check_output("good_rd_err", err, 0);
      bus_read(8'h01, rd, err);
      check_output("tcr_unchanged", rd, 8'h21);
      apply_stimulus(8'h03, 8'h55, err);
      check_output("tcnt_wr_err", err, 1);
      apply_stimulus(8'h01, 8'h81, err);
      check_output("ld_again", load, 1);
      check_output("good_wr_err", err, 0);
      bus_read(8'h01, rd, err);
      check_output("ld_reads_zero", rd, 8'h01);

      // Reset while counting at /16.
      apply_stimulus(8'h01, 8'h0D, err);
      first_k = -1;
      for (int k = 0; k < 40 && first_k < 0; k++) begin
         if (clk_ena) first_k = k;
         else @(negedge clk);
      end
      check_output("div16_seen", first_k, 15);
      #2 rst = 1'b1;
      #1;
      check_output("midrun_clk_ena", clk_ena, 0);
      check_output("midrun_load_en", {load, enable}, 0);
      check_output("midrun_start", start_counter, RST_VAL);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ticks = 0; load_hits = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (clk_ena) ticks++;
         if (load) load_hits++;
      end
      check_output("post_rst_ticks", ticks, 0);
      check_output("post_rst_load", load_hits, 0);

      // Reset in the access phase of a write: nothing may commit.
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h3C;
      @(negedge clk);
      penable = 1'b1; rst = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
      bus_read(8'h00, rd, err);
      check_output("abort_write", rd, RST_VAL);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
